// File: rtl/puf_pkg.sv
// Shared defaults and FSM state encoding for the PUF evaluation controller.
package puf_pkg;

  localparam int CW_DEF     = 3;
  localparam int VOTES_DEF  = 5;
  localparam int SETTLE_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FIRE,
    ST_SAMPLE,
    ST_DONE
  } puf_state_t;

endpackage

// File: rtl/puf_eval_ctrl_if.sv
// Host-side request/result bundle of the PUF evaluation controller.
interface puf_eval_ctrl_if import puf_pkg::*; #(
  parameter int CW = CW_DEF
) ();

  localparam int NCH = 1 << CW;

  logic           start;
  logic           sweep;
  logic [CW-1:0]  challenge_in;
  logic           busy;
  logic           resp_valid;
  logic           resp_bit;
  logic           resp_stable;
  logic           word_valid;
  logic [NCH-1:0] resp_word;
  logic [NCH-1:0] unstable_mask;

  modport master (
    output start, sweep, challenge_in,
    input  busy, resp_valid, resp_bit, resp_stable, word_valid, resp_word, unstable_mask
  );

  modport slave (
    input  start, sweep, challenge_in,
    output busy, resp_valid, resp_bit, resp_stable, word_valid, resp_word, unstable_mask
  );

endinterface

// File: rtl/puf_eval_ctrl_sync_2ff.sv
// Two-flop synchronizer bringing the arbiter response into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: drives challenge/pulse, majority-votes
// the synchronized response, single-challenge or full-sweep mode.
module puf_eval_ctrl import puf_pkg::*; #(
  parameter int CW     = CW_DEF,
  parameter int VOTES  = VOTES_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  puf_eval_ctrl_if.slave      host,
  input  logic                puf_response,
  output logic                puf_pulse,
  output logic [CW-1:0]       puf_challenge
);

  localparam int NCH = 1 << CW;
  localparam int OW  = $clog2(VOTES + 1);
  localparam int VW  = (VOTES > 1) ? $clog2(VOTES) : 1;
  localparam int IW  = $clog2(SETTLE);

  puf_state_t     r_state;
  logic [IW-1:0]  r_interval;
  logic [VW-1:0]  r_vote;
  logic [OW-1:0]  r_ones;
  logic [CW-1:0]  r_chal;
  logic           r_sweep;
  logic           r_pulse;
  logic           r_busy;
  logic           r_resp_valid;
  logic           r_word_valid;
  logic           r_resp_bit;
  logic           r_resp_stable;
  logic [NCH-1:0] r_word;
  logic [NCH-1:0] r_mask;

  logic           w_resp_sync;
  logic [OW-1:0]  w_ones_next;
  logic           w_major;
  logic           w_unstable;
  logic           w_last_vote;
  logic           w_interval_end;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (puf_response),
    .q     (w_resp_sync)
  );

  // Tally includes the vote being sampled this cycle.
  assign w_ones_next    = r_ones + OW'(w_resp_sync);
  assign w_major        = (w_ones_next > OW'(VOTES / 2));
  assign w_unstable     = (w_ones_next != '0) && (w_ones_next != OW'(VOTES));
  assign w_last_vote    = (r_vote == VW'(VOTES - 1));
  assign w_interval_end = (r_interval == IW'(SETTLE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_interval    <= '0;
      r_vote        <= '0;
      r_ones        <= '0;
      r_chal        <= '0;
      r_sweep       <= 1'b0;
      r_pulse       <= 1'b0;
      r_busy        <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_word_valid  <= 1'b0;
      r_resp_bit    <= 1'b0;
      r_resp_stable <= 1'b0;
      r_word        <= '0;
      r_mask        <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_word_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (host.start) begin
            r_state    <= ST_SETUP;
            r_busy     <= 1'b1;
            r_sweep    <= host.sweep;
            r_chal     <= host.sweep ? '0 : host.challenge_in;
            r_interval <= '0;
            r_vote     <= '0;
            r_ones     <= '0;
            if (host.sweep) begin
              r_word <= '0;
              r_mask <= '0;
            end
          end
        end
        ST_SETUP: begin
          if (w_interval_end) begin
            r_interval <= '0;
            r_pulse    <= 1'b1;
            r_state    <= ST_FIRE;
          end else begin
            r_interval <= r_interval + IW'(1);
          end
        end
        ST_FIRE: begin
          if (w_interval_end) begin
            r_interval <= '0;
            r_pulse    <= 1'b0;
            r_state    <= ST_SAMPLE;
          end else begin
            r_interval <= r_interval + IW'(1);
          end
        end
        ST_SAMPLE: begin
          r_interval <= '0;
          if (!w_last_vote) begin
            r_vote  <= r_vote + VW'(1);
            r_ones  <= w_ones_next;
            r_state <= ST_SETUP;
          end else begin
            r_vote <= '0;
            r_ones <= '0;
            if (r_sweep) begin
              r_word[r_chal] <= w_major;
              r_mask[r_chal] <= w_unstable;
            end else begin
              r_resp_bit    <= w_major;
              r_resp_stable <= !w_unstable;
            end
            // Top challenge ends the sweep instead of wrapping to 0.
            if (r_sweep && (r_chal != '1)) begin
              r_chal  <= r_chal + CW'(1);
              r_state <= ST_SETUP;
            end else begin
              r_state <= ST_DONE;
              if (r_sweep) r_word_valid <= 1'b1;
              else         r_resp_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_pulse <= 1'b0;
        end
      endcase
    end
  end

  assign puf_pulse          = r_pulse;
  assign puf_challenge      = r_chal;
  assign host.busy          = r_busy;
  assign host.resp_valid    = r_resp_valid;
  assign host.resp_bit      = r_resp_bit;
  assign host.resp_stable   = r_resp_stable;
  assign host.word_valid    = r_word_valid;
  assign host.resp_word     = r_word;
  assign host.unstable_mask = r_mask;

endmodule

// File: doc/puf_eval_ctrl.md
PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

Interface
REQ-001 Parameter CW, default 3, challenge width in bits; SHALL match the delay-line challenge width.
REQ-002 Parameter VOTES, default 5, repetitions per challenge; SHALL be odd and >=1.
REQ-003 Parameter SETTLE, default 4, cycles per pulse phase; SHALL be >=3.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request an evaluation; sampled only in IDLE.
REQ-007 sweep  in  1  sampled with start; 1 = evaluate all 2^CW challenges, 0 = evaluate challenge_in only.
REQ-008 challenge_in  in  CW  challenge for single mode; captured on start.
REQ-009 puf_response  in  1  raw response from the arbiter flip-flop; asynchronous to clk.
REQ-010 puf_pulse  out  1  race pulse driven into the delay line.
REQ-011 puf_challenge  out  CW  challenge driven into the delay line.
REQ-012 busy  out  1  high while an evaluation is in progress.
REQ-013 resp_valid  out  1  one-cycle strobe: single-mode result ready.
REQ-014 resp_bit  out  1  majority response for the single challenge.
REQ-015 resp_stable  out  1  1 when all VOTES samples agreed, single mode.
REQ-016 word_valid  out  1  one-cycle strobe: sweep result ready.
REQ-017 resp_word  out  2^CW  bit i = majority response for challenge i.
REQ-018 unstable_mask  out  2^CW  bit i = 1 if the votes for challenge i disagreed.

Function
REQ-019 FSM states: IDLE, SETUP, FIRE, SAMPLE, DONE.
- IDLE->SETUP on start.
- SETUP->FIRE after SETTLE cycles.
- FIRE->SAMPLE after SETTLE cycles.
- SAMPLE->SETUP if more votes or challenges remain, otherwise ->DONE.
- DONE->IDLE after 1 cycle.
REQ-020 puf_pulse SHALL be 1 only in FIRE and SHALL be driven from a register, glitch-free.
REQ-021 puf_challenge SHALL be registered and SHALL change only on the SETUP entry edge, never while puf_pulse=1.
REQ-022 puf_response SHALL pass through a 2-flop synchronizer; SAMPLE SHALL read the synchronized value.
REQ-023 Per challenge, a ones counter of width clog2(VOTES+1) SHALL clear at the first SETUP and increment in SAMPLE when the synchronized response is 1.
- majority = (ones > VOTES/2).
- unstable = (ones != 0 && ones != VOTES).
REQ-024 Single mode:
- one vote costs 2*SETTLE+1 cycles;
- resp_valid is high in DONE, VOTES*(2*SETTLE+1)+1 cycles after the start edge (46 at defaults);
- resp_bit and resp_stable hold until the next start.
REQ-025 Sweep mode:
- challenges run 0..2^CW-1 in ascending order;
- result bits are written after the last vote of each challenge;
- word_valid is high in DONE, 2^CW*VOTES*(2*SETTLE+1)+1 cycles after start (361 at defaults).
REQ-026 start while busy=1 SHALL be ignored; changes to challenge_in or sweep while busy SHALL be ignored.
REQ-027 busy SHALL be 1 from the cycle after start through DONE inclusive.
REQ-028 Challenge counter wrap from 2^CW-1 SHALL terminate the sweep, not restart it.
REQ-029 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.

Reset
REQ-030 rst_n low SHALL immediately force:
- state IDLE;
- puf_pulse, busy, resp_valid, word_valid = 0;
- puf_challenge, resp_bit, resp_stable, resp_word, unstable_mask = 0;
- counters and synchronizer = 0.
REQ-031 Reset mid-evaluation SHALL abort without producing any strobe; the first start after deassertion SHALL behave as from power-up.

Structure
REQ-032 Package puf_pkg SHALL hold the CW, VOTES and SETTLE defaults and the FSM state typedef.
REQ-033 One sub-module, sync_2ff, SHALL implement the response synchronizer.
REQ-034 The interval counter, vote counter, ones counter and challenge counter SHALL live in puf_eval_ctrl.

Verification
REQ-035 Single, response model constant 1, challenge_in=3'b101 -> puf_challenge=5 throughout; resp_valid at cycle 46; resp_bit=1; resp_stable=1.
REQ-036 Single, response model sequence 1,0,1,0,0 -> resp_bit=0, resp_stable=0; exactly 5 puf_pulse high windows of 4 cycles each.
REQ-037 Sweep, response = challenge parity -> word_valid at cycle 361; resp_word=8'h96; unstable_mask=0; no challenge change while puf_pulse=1.
REQ-038 start re-pulsed at cycles 10 and 46 of a single run -> both ignored; no extra strobes; the next run is accepted in the following IDLE cycle.
REQ-039 rst_n pulsed low at cycle 20 of a sweep -> all outputs 0 asynchronously; no strobe; a new single run afterwards completes in 46 cycles.
